// File: rtl/counter_date.sv
// BCD day/month counter with daily advance, year-rollover pulse and manual set mode.
// Define DATE_LEAP_YEAR_EN to give February 29 days in leap years read from the year inputs.
module counter_date #(
    parameter int unsigned RESET_MONTH = 1,
    parameter int unsigned RESET_DAY   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_date,
    input  logic       sel_month,
    input  logic       up,
    input  logic       down,
    input  logic       tick_day,
    input  logic [3:0] year_unit,
    input  logic [3:0] year_ten,
    input  logic [3:0] year_hundered,
    input  logic [3:0] year_thousand,
    output logic [3:0] day_unit,
    output logic [3:0] day_ten,
    output logic [3:0] month_unit,
    output logic [3:0] month_ten,
    output logic       tick_year
);

    localparam logic [4:0] RST_DAY   = 5'(RESET_DAY);
    localparam logic [3:0] RST_MONTH = 4'(RESET_MONTH);

    logic [4:0] r_day;
    logic [3:0] r_month;
    logic       r_tick_year;
    logic [3:0] r_day_unit, r_day_ten, r_month_unit, r_month_ten;

    logic [4:0] w_dim;
    logic [4:0] w_day_nxt;
    logic [3:0] w_month_nxt;
    logic       w_tick_nxt;
    logic       w_leap;

    function automatic logic [7:0] to_bcd(input logic [4:0] v);
        logic [3:0] t;
        logic [4:0] off;
        if (v >= 5'd30) begin
            t = 4'd3; off = 5'd30;
        end else if (v >= 5'd20) begin
            t = 4'd2; off = 5'd20;
        end else if (v >= 5'd10) begin
            t = 4'd1; off = 5'd10;
        end else begin
            t = 4'd0; off = 5'd0;
        end
        return {t, 4'(v - off)};
    endfunction

`ifdef DATE_LEAP_YEAR_EN
    // (10*a + b) mod 4 == (2*a[0] + b[1:0]) mod 4, so only low bits matter
    logic [1:0] w_yy_mod4;
    logic [1:0] w_cc_mod4;
    logic       w_unused_year_hi;
    assign w_yy_mod4 = {year_ten[0], 1'b0} + year_unit[1:0];
    assign w_cc_mod4 = {year_thousand[0], 1'b0} + year_hundered[1:0];
    assign w_leap = (year_ten == 4'd0 && year_unit == 4'd0) ? (w_cc_mod4 == 2'd0)
                                                            : (w_yy_mod4 == 2'd0);
    assign w_unused_year_hi = ^{year_thousand[3:1], year_hundered[3:2]};
`else
    logic w_unused_year;
    assign w_unused_year = ^{year_unit, year_ten, year_hundered, year_thousand};
    assign w_leap = 1'b0;
`endif

    always_comb begin
        case (r_month)
            4'd2:                      w_dim = w_leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   w_dim = 5'd30;
            default:                   w_dim = 5'd31;
        endcase
    end

    always_comb begin
        w_day_nxt   = r_day;
        w_month_nxt = r_month;
        w_tick_nxt  = 1'b0;
        // A day left beyond the current month length is pulled back before anything else
        if (r_day > w_dim) begin
            w_day_nxt = w_dim;
        end else if (mode_date) begin
            if (tick_day) begin
                if (r_day >= w_dim) begin
                    w_day_nxt = 5'd1;
                    if (r_month >= 4'd12) begin
                        w_month_nxt = 4'd1;
                        w_tick_nxt  = 1'b1;
                    end else begin
                        w_month_nxt = r_month + 4'd1;
                    end
                end else begin
                    w_day_nxt = r_day + 5'd1;
                end
            end
        end else if (up ^ down) begin
            if (sel_month) begin
                if (up) w_month_nxt = (r_month >= 4'd12) ? 4'd1  : r_month + 4'd1;
                else    w_month_nxt = (r_month <= 4'd1)  ? 4'd12 : r_month - 4'd1;
            end else begin
                if (up) w_day_nxt = (r_day >= w_dim) ? 5'd1  : r_day + 5'd1;
                else    w_day_nxt = (r_day <= 5'd1)  ? w_dim : r_day - 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_day                      <= RST_DAY;
            r_month                    <= RST_MONTH;
            r_tick_year                <= 1'b0;
            {r_day_ten, r_day_unit}    <= to_bcd(RST_DAY);
            {r_month_ten, r_month_unit} <= to_bcd({1'b0, RST_MONTH});
        end else begin
            r_day                      <= w_day_nxt;
            r_month                    <= w_month_nxt;
            r_tick_year                <= w_tick_nxt;
            {r_day_ten, r_day_unit}    <= to_bcd(w_day_nxt);
            {r_month_ten, r_month_unit} <= to_bcd({1'b0, w_month_nxt});
        end
    end

    assign day_unit   = r_day_unit;
    assign day_ten    = r_day_ten;
    assign month_unit = r_month_unit;
    assign month_ten  = r_month_ten;
    assign tick_year  = r_tick_year;

endmodule

// File: tb/tb_counter_date.sv
// Scoreboard bench for counter_date: stimulus queues expected dates, a monitor checks them.
module tb_counter_date;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, mode_date = 1'b0, sel_month = 1'b0;
    logic       up = 1'b0, down = 1'b0, tick_day = 1'b0;
    logic [3:0] year_unit = 4'd3, year_ten = 4'd2, year_hundered = 4'd0, year_thousand = 4'd2;
    logic [3:0] day_unit, day_ten, month_unit, month_ten;
    logic       tick_year;

    counter_date #(.RESET_MONTH(1), .RESET_DAY(1)) dut (
        .clk(clk), .rst(rst), .mode_date(mode_date), .sel_month(sel_month),
        .up(up), .down(down), .tick_day(tick_day),
        .year_unit(year_unit), .year_ten(year_ten),
        .year_hundered(year_hundered), .year_thousand(year_thousand),
        .day_unit(day_unit), .day_ten(day_ten),
        .month_unit(month_unit), .month_ten(month_ten),
        .tick_year(tick_year)
    );

    typedef struct {
        bit    chk_date;
        int    day;
        int    month;
        bit    chk_tick;
        bit    tick;
        string name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   year_now = 2023;

    // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge
    task automatic cyc(input bit r, input bit m, input bit sm, input bit u, input bit d, input bit t,
                       input bit cd, input int ed, input int em, input bit ct, input bit et,
                       input string nm);
        exp_t e;
        @(negedge clk);
        rst = r; mode_date = m; sel_month = sm; up = u; down = d; tick_day = t;
        year_thousand = 4'(year_now / 1000);
        year_hundered = 4'((year_now / 100) % 10);
        year_ten      = 4'((year_now / 10) % 10);
        year_unit     = 4'(year_now % 10);
        e.chk_date = cd; e.day = ed; e.month = em; e.chk_tick = ct; e.tick = et; e.name = nm;
        q.push_back(e);
    endtask

    task automatic run(input bit t, input int ed, input int em, input bit et, input string nm);
        cyc(0, 1, 0, 0, 0, t, 1, ed, em, 1, et, nm);
    endtask

    task automatic set(input bit sm, input bit u, input bit d, input int ed, input int em,
                       input string nm);
        cyc(0, 0, sm, u, d, 0, 1, ed, em, 1, 0, nm);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk_date) begin
                    checks++;
                    if (day_ten !== 4'(e.day / 10) || day_unit !== 4'(e.day % 10) ||
                        month_ten !== 4'(e.month / 10) || month_unit !== 4'(e.month % 10)) begin
                        errors++;
                        $display("FAIL %s: got day %h%h month %h%h, required day %0d month %0d",
                                 e.name, day_ten, day_unit, month_ten, month_unit, e.day, e.month);
                    end
                end
                if (e.chk_tick) begin
                    checks++;
                    if (tick_year !== e.tick) begin
                        errors++;
                        $display("FAIL %s tick_year: got %b, required %b", e.name, tick_year, e.tick);
                    end
                end
            end
        end
    end

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, "reset");
        for (int k = 1; k <= 31; k++)
            run(1, (k == 31) ? 1 : k + 1, (k == 31) ? 2 : 1, 0, "jan_ticks");
        run(0, 1, 2, 0, "idle_feb1");

        set(1, 0, 1, 1, 1, "mon_dn");
        set(1, 0, 1, 1, 12, "mon_dn_wrap");
        set(0, 0, 1, 31, 12, "day_dn_wrap_dec");
        run(1, 1, 1, 1, "new_year");
        run(1, 2, 1, 0, "after_new_year");
        run(0, 2, 1, 0, "idle_jan2");
        cyc(0, 1, 0, 1, 0, 0, 1, 2, 1, 1, 0, "run_ignores_up");

        set(1, 1, 0, 2, 2, "mon_up_feb");
        set(0, 0, 1, 1, 2, "day_dn");
        set(0, 0, 1, 28, 2, "feb_wrap_2023");
        year_now = 2024;
`ifdef DATE_LEAP_YEAR_EN
        run(1, 29, 2, 0, "leap_2024");
        run(1, 1, 3, 0, "leap_2024_mar");
`else
        run(1, 1, 3, 0, "noleap_2024");
`endif
        year_now = 2023;
        set(1, 0, 1, 1, 2, "back_to_feb");
        set(0, 0, 1, 28, 2, "feb28_again");
        year_now = 1900;
        run(1, 1, 3, 0, "y1900");
        set(1, 0, 1, 1, 2, "back_to_feb_1900");
        set(0, 0, 1, 28, 2, "feb28_1900");
        year_now = 2000;
`ifdef DATE_LEAP_YEAR_EN
        run(1, 29, 2, 0, "leap_2000");
        year_now = 2023;
        set(0, 0, 0, 28, 2, "year_change_clamp");
`else
        run(1, 1, 3, 0, "noleap_2000");
        year_now = 2023;
`endif

        cyc(1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, "reset2");
        set(1, 1, 0, 1, 2, "mon_up_2");
        set(1, 1, 0, 1, 3, "mon_up_3");
        set(1, 1, 0, 1, 4, "mon_up_4");
        for (int k = 1; k <= 30; k++)
            set(0, 1, 0, (k == 30) ? 1 : k + 1, 4, "apr_up_hold");
        set(0, 0, 1, 30, 4, "apr_dn_wrap");
        for (int k = 0; k < 10; k++)
            set(0, 1, 1, 30, 4, "both_hold");

        set(1, 0, 1, 30, 3, "mon_dn_mar");
        set(0, 1, 0, 31, 3, "mar31");
        set(1, 0, 1, 31, 2, "mon_dn_feb");
        set(0, 0, 0, 28, 2, "month_clamp");
        set(1, 0, 1, 28, 1, "mon_dn_jan");
        set(1, 0, 1, 28, 12, "mon_dn_dec");
        set(1, 1, 0, 28, 1, "mon_up_wrap_no_tick");
        cyc(0, 0, 0, 0, 0, 1, 1, 28, 1, 1, 0, "set_ignores_tick");

        set(0, 1, 0, 29, 1, "up_hold_a");
        set(0, 1, 0, 30, 1, "up_hold_b");
        cyc(1, 1, 0, 1, 0, 1, 1, 1, 1, 1, 0, "reset_mid_hold");
        cyc(0, 0, 0, 1, 0, 0, 1, 2, 1, 1, 0, "after_reset_up");

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
